nco_clk_gen: RTL and testbench



---
 rtl/nco_clk_gen_pkg.sv | 29 ++
 rtl/nco_clk_gen_ch.sv | 80 ++++++++
 rtl/nco_clk_gen.sv | 100 ++++++++++
 tb/tb_nco_clk_gen.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nco_clk_gen_pkg.sv
// nco_clk_gen_pkg
//   Shared definitions for the NCO clock-enable generator:
//   - ACC_W_DEF / LOCK_CNT_DEF : default accumulator width and lock wrap count
//   - SLOT_CH_W / SLOT_INC_W   : field widths of the pending configuration slot,
//                                sized for the largest supported build
//                                (16 channels, 64-bit accumulator)
//   - cfg_slot_t               : pending configuration slot {ch, inc}
//   - inc_for()                : phase increment for a wanted output frequency
package nco_clk_gen_pkg;

  localparam int ACC_W_DEF    = 32;
  localparam int LOCK_CNT_DEF = 4;

  localparam int SLOT_CH_W  = 5;
  localparam int SLOT_INC_W = 64;

  typedef struct packed {
    logic [SLOT_CH_W-1:0]  ch;
    logic [SLOT_INC_W-1:0] inc;
  } cfg_slot_t;

  // round(f_out * 2^acc_w / f_ref), integer arithmetic only
  function automatic longint unsigned inc_for(input longint unsigned f_ref_hz,
                                              input longint unsigned f_out_hz,
                                              input int unsigned     acc_w);
    return ((f_out_hz << acc_w) + (f_ref_hz >> 1)) / f_ref_hz;
  endfunction

endpackage

// File: rtl/nco_clk_gen_ch.sv
// nco_clk_gen_ch
//   One NCO channel: phase accumulator, increment register, lock counter and
//   registered outputs.
//   Ports:
//     refclk, rst_n  : clock, async active-low reset
//     load           : replace the increment on this edge (accumulator untouched)
//     load_inc       : increment value used when load is high
//     hold_lock      : keep the lock counter cleared and locked low
//     carry          : combinational carry-out of acc + inc this cycle
//     inc_zero       : current increment is zero (channel frozen)
//     outclk_en      : registered carry, one cycle behind the wrap
//     outclk         : registered accumulator MSB
//     locked         : registered (lock counter == LOCK_CNT)
module nco_clk_gen_ch
  import nco_clk_gen_pkg::*;
#(
  parameter int               ACC_W    = ACC_W_DEF,
  parameter logic [ACC_W-1:0] INC_RST  = '0,
  parameter int               LOCK_CNT = LOCK_CNT_DEF
)(
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [ACC_W-1:0] load_inc,
  input  logic             hold_lock,
  output logic             carry,
  output logic             inc_zero,
  output logic             outclk_en,
  output logic             outclk,
  output logic             locked
);

  localparam int               CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_CNT);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_inc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_en;
  logic             r_clk;
  logic             r_locked;
  logic [ACC_W-1:0] w_sum;
  logic             w_sat;

  // With inc == 0 the sum equals acc and carry is 0, so a zero increment
  // freezes the channel without any special-case logic.
  assign {carry, w_sum} = {1'b0, r_acc} + {1'b0, r_inc};
  assign inc_zero       = (r_inc == '0);
  assign w_sat          = (r_cnt == CNT_MAX);

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_inc    <= INC_RST;
      r_cnt    <= '0;
      r_en     <= 1'b0;
      r_clk    <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      // Accumulator keeps its wrapped value on a load: phase stays continuous.
      r_acc <= w_sum;
      r_en  <= carry;
      r_clk <= w_sum[ACC_W-1];
      if (load)
        r_inc <= load_inc;
      // Wraps while an update is pending (including the apply edge) are
      // old-rate wraps and must not count toward lock.
      if (hold_lock)
        r_cnt <= '0;
      else if (carry && !w_sat)
        r_cnt <= r_cnt + 1'b1;
      r_locked <= !hold_lock && w_sat;
    end
  end

  assign outclk_en = r_en;
  assign outclk    = r_clk;
  assign locked    = r_locked;

endmodule

// File: rtl/nco_clk_gen.sv
// nco_clk_gen
//   Multi-channel NCO clock-enable generator. NUM_CH phase-accumulator
//   channels run off refclk; a single pending slot carries runtime rate
//   changes, which take effect on the target channel's next wrap so the
//   output phase is continuous.
//   Ports:
//     refclk, rst_n        : clock, async active-low reset
//     cfg_valid/cfg_ready  : configuration handshake (one pending slot)
//     cfg_ch, cfg_inc      : target channel and new phase increment
//     cfg_err              : one-cycle pulse after an out-of-range cfg_ch accept
//     outclk_en[NUM_CH]    : per-channel enable strobe
//     outclk[NUM_CH]       : per-channel square wave (inc <= 2^(ACC_W-1))
//     locked[NUM_CH]       : per-channel rate-stable flag
module nco_clk_gen
  import nco_clk_gen_pkg::*;
#(
  parameter int               NUM_CH   = 2,
  parameter int               ACC_W    = ACC_W_DEF,
  parameter logic [ACC_W-1:0] INC_RST  = ACC_W'(32'hAAAAAAAB),
  parameter int               LOCK_CNT = LOCK_CNT_DEF,
  localparam int              CH_W     = $clog2(NUM_CH+1)
)(
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] outclk_en,
  output logic [NUM_CH-1:0] outclk,
  output logic [NUM_CH-1:0] locked
);

  logic              r_slot_vld;
  cfg_slot_t         r_slot;
  logic              r_err;

  logic              w_accept;
  logic              w_in_range;
  logic [ACC_W-1:0]  w_load_inc;
  logic [NUM_CH-1:0] w_slot_tgt;
  logic [NUM_CH-1:0] w_cfg_tgt;
  logic [NUM_CH-1:0] w_carry;
  logic [NUM_CH-1:0] w_inc_zero;
  logic [NUM_CH-1:0] w_load;
  logic [NUM_CH-1:0] w_hold;

  assign cfg_ready  = ~r_slot_vld;
  assign cfg_err    = r_err;
  assign w_accept   = cfg_valid & ~r_slot_vld;
  assign w_in_range = (cfg_ch < CH_W'(NUM_CH));
  assign w_load_inc = r_slot.inc[ACC_W-1:0];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign w_slot_tgt[c] = r_slot_vld && (r_slot.ch == SLOT_CH_W'(c));
    assign w_cfg_tgt[c]  = w_accept && w_in_range && (cfg_ch == CH_W'(c));
    // Apply on the target's wrap, or straight away if it is frozen.
    assign w_load[c]     = w_slot_tgt[c] && (w_carry[c] || w_inc_zero[c]);
    // Lock is dropped on the accept edge and held off until after apply.
    assign w_hold[c]     = w_slot_tgt[c] || w_cfg_tgt[c];

    nco_clk_gen_ch #(
      .ACC_W    (ACC_W),
      .INC_RST  (INC_RST),
      .LOCK_CNT (LOCK_CNT)
    ) u_ch (
      .refclk    (refclk),
      .rst_n     (rst_n),
      .load      (w_load[c]),
      .load_inc  (w_load_inc),
      .hold_lock (w_hold[c]),
      .carry     (w_carry[c]),
      .inc_zero  (w_inc_zero[c]),
      .outclk_en (outclk_en[c]),
      .outclk    (outclk[c]),
      .locked    (locked[c])
    );
  end

  // Accept and apply are mutually exclusive: accept needs an empty slot,
  // apply needs a full one.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_vld <= 1'b0;
      r_slot     <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_accept & ~w_in_range;
      if (w_accept && w_in_range) begin
        r_slot_vld <= 1'b1;
        r_slot.ch  <= SLOT_CH_W'(cfg_ch);
        r_slot.inc <= SLOT_INC_W'(cfg_inc);
      end else if (|w_load) begin
        r_slot_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nco_clk_gen.sv
module tb_nco_clk_gen;

  localparam int NCH = 2;
  localparam int LCK = 4;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_ch = 2'd0;
  logic [7:0] cfg_inc = 8'd0;
  logic       cfg_ready;
  logic       cfg_err;
  logic [1:0] outclk_en;
  logic [1:0] outclk;
  logic [1:0] locked;

  always #5 refclk = ~refclk;

  nco_clk_gen #(
    .NUM_CH   (2),
    .ACC_W    (8),
    .INC_RST  (8'h80),
    .LOCK_CNT (4)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_inc   (cfg_inc),
    .cfg_err   (cfg_err),
    .outclk_en (outclk_en),
    .outclk    (outclk),
    .locked    (locked)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  m_acc[NCH];
  int  m_inc[NCH];
  int  m_wraps[NCH];  // wraps seen at the current stable rate, capped at LCK
  bit  m_en[NCH];
  bit  m_clk[NCH];
  bit  m_lock[NCH];
  bit  m_err;
  bit  m_pend;
  int  m_pch;
  int  m_pinc;

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_acc[c] = 0; m_inc[c] = 128; m_wraps[c] = 0;
      m_en[c] = 0; m_clk[c] = 0; m_lock[c] = 0;
    end
    m_err = 0; m_pend = 0; m_pch = 0; m_pinc = 0;
  endfunction

  function automatic void model_edge();
    bit take;
    bit apply;
    bit unstable;
    bit wrap[NCH];
    int nxt[NCH];
    take = cfg_valid && !m_pend;
    for (int c = 0; c < NCH; c++) begin
      nxt[c]  = m_acc[c] + m_inc[c];
      wrap[c] = (nxt[c] >= 256);
      nxt[c]  = nxt[c] % 256;
    end
    apply = m_pend && (wrap[m_pch] || m_inc[m_pch] == 0);
    for (int c = 0; c < NCH; c++) begin
      unstable = (m_pend && m_pch == c) || (take && int'(cfg_ch) == c);
      m_lock[c] = !unstable && (m_wraps[c] == LCK);
      if (unstable) m_wraps[c] = 0;
      else if (wrap[c]) m_wraps[c] = (m_wraps[c] + 1 > LCK) ? LCK : m_wraps[c] + 1;
      m_en[c]  = wrap[c];
      m_acc[c] = nxt[c];
      m_clk[c] = (nxt[c] >= 128);
    end
    if (apply) begin
      m_inc[m_pch] = m_pinc;
      m_pend = 0;
    end
    m_err = take && (int'(cfg_ch) >= NCH);
    if (take && int'(cfg_ch) < NCH) begin
      m_pend = 1; m_pch = int'(cfg_ch); m_pinc = int'(cfg_inc);
    end
  endfunction

  // ---------------- every-cycle compare ----------------
  bit cmp_on = 0;

  always @(negedge refclk) begin
    if (cmp_on && rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        check($sformatf("outclk_en[%0d]", c), int'(outclk_en[c]), int'(m_en[c]));
        if (m_inc[c] <= 128)
          check($sformatf("outclk[%0d]", c), int'(outclk[c]), int'(m_clk[c]));
        check($sformatf("locked[%0d]", c), int'(locked[c]), int'(m_lock[c]));
      end
      check("cfg_err", int'(cfg_err), int'(m_err));
      check("cfg_ready", int'(cfg_ready), int'(!m_pend));
    end
  end

  // ---------------- stimulus helpers ----------------
  int tcount = 0;
  int last_t[NCH];
  int last_iv[NCH];
  int min_iv[NCH];
  int npulse[NCH];

  task automatic clr_stats();
    for (int c = 0; c < NCH; c++) begin
      last_t[c] = -1; last_iv[c] = 0; min_iv[c] = 1000; npulse[c] = 0;
    end
  endtask

  task automatic step();
    @(posedge refclk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    tcount++;
    for (int c = 0; c < NCH; c++) begin
      if (outclk_en[c]) begin
        if (last_t[c] >= 0) begin
          last_iv[c] = tcount - last_t[c];
          if (last_iv[c] < min_iv[c]) min_iv[c] = last_iv[c];
        end
        last_t[c] = tcount;
        npulse[c]++;
      end
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Hold a request until it transfers; returns cycles spent waiting.
  task automatic cfg_send(input int ch, input int inc, output int waited);
    cfg_valid = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_inc   = 8'(inc);
    waited    = 0;
    while (!cfg_ready && waited < 400) begin
      step();
      waited++;
    end
    if (!cfg_ready) check("cfg handshake timeout", waited, 0);
    else step();
    cfg_valid = 1'b0;
  endtask

  function automatic int pick_inc();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 0;
    if (r == 1) return 128;
    if (r == 2) return 255;
    if (r <= 4) return int'($urandom_range(1, 8));
    return int'($urandom_range(1, 128));
  endfunction

  // ---------------- main sequence ----------------
  initial begin : main
    int w;
    int hold;
    int v;
    bit take;
    model_reset();
    clr_stats();

    // Reset state
    steps(3);
    check("reset outclk_en", int'(outclk_en), 0);
    check("reset outclk", int'(outclk), 0);
    check("reset locked", int'(locked), 0);
    check("reset cfg_err", int'(cfg_err), 0);
    check("reset cfg_ready", int'(cfg_ready), 1);

    // 1: release, period 2, lock one cycle after 4th pulse
    rst_n = 1'b1;
    cmp_on = 1;
    clr_stats();
    steps(8);
    check("t1 pulses ch0", npulse[0], 4);
    check("t1 pulses ch1", npulse[1], 4);
    check("t1 period ch0", last_iv[0], 2);
    check("t1 not yet locked", int'(locked), 0);
    step();
    check("t1 locked", int'(locked), 3);
    check("t1 model locked", int'(m_lock[0]) + int'(m_lock[1]), 2);

    // 2: retune ch1 to 0x40
    steps(3);
    clr_stats();
    cfg_send(1, 8'h40, w);
    check("t2 locked after accept", int'(locked), 1);
    steps(40);
    check("t2 no double pulse", int'(min_iv[1] >= 2), 1);
    check("t2 new period ch1", last_iv[1], 4);
    check("t2 ch0 pulses", npulse[0], 20);
    check("t2 relocked", int'(locked), 3);

    // 3: back-to-back requests
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_inc = 8'h20;
    step();
    check("t3 ready drops", int'(cfg_ready), 0);
    cfg_send(1, 8'h10, w);
    check("t3 second waited", int'(w >= 1), 1);
    steps(150);
    check("t3 period ch0", last_iv[0], 8);
    check("t3 period ch1", last_iv[1], 16);
    check("t3 locked", int'(locked), 3);

    // 4: out-of-range channel
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_inc = 8'h01;
    step();
    cfg_valid = 1'b0;
    check("t4 cfg_err pulse", int'(cfg_err), 1);
    check("t4 ready stays", int'(cfg_ready), 1);
    step();
    check("t4 cfg_err single", int'(cfg_err), 0);
    check("t4 locked kept", int'(locked), 3);

    // 5: freeze ch0, then restart at 0x80
    cfg_send(0, 0, w);
    steps(20);
    v = int'(outclk[0]);
    clr_stats();
    steps(10);
    check("t5 frozen pulses", npulse[0], 0);
    check("t5 outclk holds", int'(outclk[0]), v);
    check("t5 frozen unlocked", int'(locked[0]), 0);
    cfg_send(0, 8'h80, w);
    check("t5 ready low pending", int'(cfg_ready), 0);
    step();
    check("t5 applied next cycle", int'(cfg_ready), 1);
    clr_stats();
    steps(10);
    check("t5 resumed pulses", npulse[0], 5);

    // 6: reset while ch1 update pending
    cfg_send(1, 8'h08, w);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t6 outclk_en", int'(outclk_en), 0);
    check("t6 outclk", int'(outclk), 0);
    check("t6 locked", int'(locked), 0);
    check("t6 cfg_ready", int'(cfg_ready), 1);
    steps(2);
    rst_n = 1'b1;
    clr_stats();
    steps(20);
    check("t6 ch1 pulses", npulse[1], 10);
    check("t6 ch1 period", last_iv[1], 2);
    check("t6 ch0 pulses", npulse[0], 10);

    // Random configuration traffic
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!cfg_valid && $urandom_range(0, 3) == 0) begin
        cfg_valid = 1'b1;
        cfg_ch    = 2'($urandom_range(0, 3));
        cfg_inc   = 8'(pick_inc());
        hold      = 0;
      end
      take = cfg_valid && cfg_ready;
      step();
      if (take) cfg_valid = 1'b0;
      else if (cfg_valid) begin
        hold++;
        if (hold > 400) begin
          check("random handshake stall", hold, 0);
          cfg_valid = 1'b0;
        end
      end
    end

    cmp_on = 0;
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
